// File: rtl/led_matrix_scanner.sv
// Scans the N*N cell vector onto a column-multiplexed LED matrix, one column per 2**DIV-cycle slot.
// New generations are double-buffered and swapped only at frame end; dead-time blanking and PWM gate each slot.
module led_matrix_scanner #(
    parameter int N    = 5,
    parameter int DIV  = 12,
    parameter int DEAD = 16,
    parameter int BW   = 4,
    localparam int XW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*N-1:0]    cells_in,
    input  logic              frame_valid,
    input  logic [BW-1:0]     brightness,
    output logic [N-1:0]      cols,
    output logic [N-1:0]      rows,
    output logic [XW-1:0]     x,
    output logic              frame_sync
);

    localparam logic [DIV-1:0] DEAD_C = DIV'(DEAD);
    localparam logic [XW-1:0]  X_LAST = XW'(N - 1);

    logic [DIV-1:0] sc;
    logic [N*N-1:0] shadow;
    logic [N*N-1:0] display;
    logic           pending;

    logic           slot_end;
    logic           frame_end;
    logic           en;
    logic [N-1:0]   col_bits;

    assign slot_end  = &sc;
    assign frame_end = slot_end && (x == X_LAST);
    // Dead time first, then the top BW bits of sc act as the PWM ramp.
    assign en        = (sc >= DEAD_C) && (sc[DIV-1 -: BW] < brightness);

    always_comb begin
        col_bits = '0;
        for (int y = 0; y < N; y++) begin
            for (int c = 0; c < N; c++) begin
                if (x == XW'(c)) begin
                    col_bits[y] = display[N*y + c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            sc         <= '0;
            shadow     <= '0;
            display    <= '0;
            pending    <= 1'b0;
            cols       <= '0;
            rows       <= '1;
            frame_sync <= 1'b0;
        end else begin
            sc <= sc + DIV'(1);
            if (slot_end) begin
                x <= (x == X_LAST) ? '0 : x + XW'(1);
            end

            if (frame_valid) begin
                shadow  <= cells_in;
                pending <= 1'b1;
            end

            // A strobe landing on the swap cycle bypasses the shadow so the newest frame wins.
            if (frame_end) begin
                if (frame_valid) begin
                    display <= cells_in;
                end else if (pending) begin
                    display <= shadow;
                end
                pending <= 1'b0;
            end

            cols       <= en ? (N'(1) << x) : '0;
            rows       <= en ? ~col_bits : '1;
            frame_sync <= frame_end;
        end
    end

endmodule
